ws2812_decoder: RTL

- Receives a WS2812-style single-wire NRZ pulse stream and recovers the bytes carried on it, MSB first.
- Each high pulse is classified by its width in clk cycles: a long pulse is a 1, a short pulse is a 0.
- A long low gap marks the end of a frame.
- Sits on the LED data line, or on a loopback tap of our own driver output, and hands bytes to the UART send path for readback and verification of strip data.

---
 rtl/ws2812_decoder.sv | 225 ++++++++++++++++++++++
 1 files changed

// File: rtl/ws2812_decoder.sv
// ws2812_decoder: recovers MSB-first bytes from a WS2812-style NRZ pulse line.
// Each high pulse is classified by width (long = 1, short = 0), and a long
// low gap marks end of frame. Decoded bytes are offered on a valid/ack handshake.
//
// Ports:
//   clk          system clock
//   rst          asynchronous active-high reset
//   din          raw data line (asynchronous to clk)
//   dat_out      decoded byte
//   dat_valid    dat_out holds an unconsumed byte
//   dat_ack      consumer takes the byte when dat_ack && dat_valid
//   byte_idx     0-based index of dat_out within its frame
//   frame_end    one-cycle pulse on a reset gap that follows at least one pulse
//   err_glitch   sticky: high pulse shorter than MIN_HIGH
//   err_long     sticky: high pulse longer than MAX_HIGH
//   err_partial  sticky: frame ended with 1..7 bits pending
//   err_overrun  sticky: byte dropped because dat_valid was still set
//   err_clr      synchronous clear of all sticky errors (wins over set events)
module ws2812_decoder #(
  parameter int unsigned SYNC_STAGES  = 2,
  parameter int unsigned MIN_HIGH     = 3,
  parameter int unsigned ONE_THRESH   = 8,
  parameter int unsigned MAX_HIGH     = 14,
  parameter int unsigned RESET_CYCLES = 512
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       din,
  output logic [7:0] dat_out,
  output logic       dat_valid,
  input  logic       dat_ack,
  output logic [9:0] byte_idx,
  output logic       frame_end,
  output logic       err_glitch,
  output logic       err_long,
  output logic       err_partial,
  output logic       err_overrun,
  input  logic       err_clr
);

  localparam int unsigned HCNT_W = 5;
  localparam int unsigned LCNT_W = $clog2(RESET_CYCLES) + 1;
  localparam int unsigned IDX_W  = 10;
  localparam logic [HCNT_W-1:0] HCNT_MAX = '1;
  localparam logic [LCNT_W-1:0] LCNT_END = LCNT_W'(RESET_CYCLES);

  typedef enum logic [1:0] {ST_SYNC, ST_IDLE, ST_HIGH, ST_LOW} state_t;

  // Input synchronizer plus one history flop for edge detection
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s;
  logic                   s_q;
  logic                   rise;
  logic                   fall;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
      s_q    <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], din};
      s_q    <= s;
    end
  end

  assign s    = sync_q[SYNC_STAGES-1];
  assign rise = s & ~s_q;
  assign fall = ~s & s_q;

  // Registered state
  state_t            state, state_d;
  logic [HCNT_W-1:0] hcnt, hcnt_d;
  logic [LCNT_W-1:0] lcnt, lcnt_d;
  logic [2:0]        bitcnt, bitcnt_d;
  logic [7:0]        sr, sr_d;
  logic [IDX_W-1:0]  idx, idx_d;
  logic [7:0]        dat_out_d;
  logic              dat_valid_d;
  logic [IDX_W-1:0]  byte_idx_d;
  logic              frame_end_d;
  logic              err_glitch_d, err_long_d, err_partial_d, err_overrun_d;

  // Combinational helpers
  logic       bit_val;
  logic [7:0] shifted;
  logic       byte_done;
  logic       set_glitch, set_long, set_partial, set_overrun;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_SYNC;
      hcnt        <= '0;
      lcnt        <= '0;
      bitcnt      <= '0;
      sr          <= '0;
      idx         <= '0;
      dat_out     <= '0;
      dat_valid   <= 1'b0;
      byte_idx    <= '0;
      frame_end   <= 1'b0;
      err_glitch  <= 1'b0;
      err_long    <= 1'b0;
      err_partial <= 1'b0;
      err_overrun <= 1'b0;
    end else begin
      state       <= state_d;
      hcnt        <= hcnt_d;
      lcnt        <= lcnt_d;
      bitcnt      <= bitcnt_d;
      sr          <= sr_d;
      idx         <= idx_d;
      dat_out     <= dat_out_d;
      dat_valid   <= dat_valid_d;
      byte_idx    <= byte_idx_d;
      frame_end   <= frame_end_d;
      err_glitch  <= err_glitch_d;
      err_long    <= err_long_d;
      err_partial <= err_partial_d;
      err_overrun <= err_overrun_d;
    end
  end

  // Next-state, pulse classification, handshake and sticky errors
  always_comb begin
    state_d     = state;
    hcnt_d      = hcnt;
    lcnt_d      = lcnt;
    bitcnt_d    = bitcnt;
    sr_d        = sr;
    idx_d       = idx;
    dat_out_d   = dat_out;
    dat_valid_d = dat_valid;
    byte_idx_d  = byte_idx;
    frame_end_d = 1'b0;
    set_glitch  = 1'b0;
    set_long    = 1'b0;
    set_partial = 1'b0;
    set_overrun = 1'b0;
    byte_done   = 1'b0;
    bit_val     = (hcnt >= HCNT_W'(ONE_THRESH));
    shifted     = {sr[6:0], bit_val};

    unique case (state)
      // Wait for a full reset gap so decoding never starts mid-frame
      ST_SYNC: begin
        if (s) begin
          lcnt_d = '0;
        end else if (lcnt == LCNT_END) begin
          state_d  = ST_IDLE;
          lcnt_d   = '0;
          bitcnt_d = '0;
          sr_d     = '0;
          idx_d    = '0;
        end else begin
          lcnt_d = lcnt + LCNT_W'(1);
        end
      end
      ST_IDLE: begin
        if (rise) begin
          hcnt_d  = HCNT_W'(1);
          state_d = ST_HIGH;
        end
      end
      ST_HIGH: begin
        if (fall) begin
          if (hcnt < HCNT_W'(MIN_HIGH)) begin
            set_glitch = 1'b1;
            lcnt_d     = LCNT_W'(1);
            state_d    = ST_LOW;
          end else if (hcnt > HCNT_W'(MAX_HIGH)) begin
            set_long = 1'b1;
            sr_d     = '0;
            bitcnt_d = '0;
            lcnt_d   = '0;
            state_d  = ST_SYNC;
          end else begin
            sr_d      = shifted;
            bitcnt_d  = bitcnt + 3'd1;
            byte_done = (bitcnt == 3'd7);
            lcnt_d    = LCNT_W'(1);
            state_d   = ST_LOW;
          end
        end else if (hcnt != HCNT_MAX) begin
          hcnt_d = hcnt + HCNT_W'(1);
        end
      end
      ST_LOW: begin
        if (rise) begin
          hcnt_d  = HCNT_W'(1);
          state_d = ST_HIGH;
        end else if (lcnt == LCNT_END) begin
          frame_end_d = 1'b1;
          set_partial = (bitcnt != 3'd0);
          bitcnt_d    = '0;
          sr_d        = '0;
          idx_d       = '0;
          state_d     = ST_IDLE;
        end else begin
          lcnt_d = lcnt + LCNT_W'(1);
        end
      end
      default: state_d = ST_SYNC;
    endcase

    // A completed byte may replace a byte being acked in the same cycle
    if (byte_done) begin
      if (!dat_valid || dat_ack) begin
        dat_out_d   = shifted;
        byte_idx_d  = idx;
        dat_valid_d = 1'b1;
      end else begin
        set_overrun = 1'b1;
      end
      idx_d = idx + IDX_W'(1);
    end else if (dat_valid && dat_ack) begin
      dat_valid_d = 1'b0;
    end

    err_glitch_d  = err_clr ? 1'b0 : (err_glitch  | set_glitch);
    err_long_d    = err_clr ? 1'b0 : (err_long    | set_long);
    err_partial_d = err_clr ? 1'b0 : (err_partial | set_partial);
    err_overrun_d = err_clr ? 1'b0 : (err_overrun | set_overrun);
  end

endmodule
